// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, command opcodes, TAP next-state function.
package jtag_pkg;

    localparam logic [3:0] TEST_LOGIC_RESET = 4'd15;
    localparam logic [3:0] RUN_TEST_IDLE    = 4'd12;
    localparam logic [3:0] SELECT_DR_SCAN   = 4'd7;
    localparam logic [3:0] CAPTURE_DR       = 4'd6;
    localparam logic [3:0] SHIFT_DR         = 4'd2;
    localparam logic [3:0] EXIT1_DR         = 4'd1;
    localparam logic [3:0] PAUSE_DR         = 4'd3;
    localparam logic [3:0] EXIT2_DR         = 4'd0;
    localparam logic [3:0] UPDATE_DR        = 4'd5;
    localparam logic [3:0] SELECT_IR_SCAN   = 4'd4;
    localparam logic [3:0] CAPTURE_IR       = 4'd14;
    localparam logic [3:0] SHIFT_IR         = 4'd10;
    localparam logic [3:0] EXIT1_IR         = 4'd9;
    localparam logic [3:0] PAUSE_IR         = 4'd11;
    localparam logic [3:0] EXIT2_IR         = 4'd8;
    localparam logic [3:0] UPDATE_IR        = 4'd13;

    localparam logic [1:0] OP_TAP_RESET = 2'd0;
    localparam logic [1:0] OP_IDLE      = 2'd1;
    localparam logic [1:0] OP_SHIFT_IR  = 2'd2;
    localparam logic [1:0] OP_SHIFT_DR  = 2'd3;

    typedef enum logic [2:0] {
        RST_EXIT,
        READY,
        PRE,
        SHIFT,
        POST,
        IDLE_RUN,
        TLR_SEQ
    } drv_state_e;

    // Standard IEEE 1149.1 TAP controller transition
    function automatic logic [3:0] tap_next(input logic [3:0] state, input logic tms);
        logic [3:0] nxt;
        case (state)
            TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          nxt = TEST_LOGIC_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_host_driver_mirror.sv
// Registered copy of the target TAP state, advanced by the driven TMS every clock.
module jtag_tap_mirror
    import jtag_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       tms,
    output logic [3:0] tap_state
);

    // Follow the target TAP; reset puts both in TEST_LOGIC_RESET
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tap_state <= TEST_LOGIC_RESET;
        end else begin
            tap_state <= tap_next(tap_state, tms);
        end
    end

endmodule

// File: rtl/jtag_host_driver.sv
// Host-side JTAG driver: turns reset/idle/IR/DR commands into cycle-exact TMS/TDI and
// returns the captured TDO bits.
module jtag_host_driver
    import jtag_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic [3:0]         tap_state
);

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    drv_state_e         state_q;
    logic [2:0]         step_q;
    logic [LEN_W-1:0]   bitcnt_q;
    logic [LEN_W-1:0]   len_q;
    logic               is_ir_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap_q;
    logic [MAX_LEN-1:0] mask_q;
    logic [LEN_W-1:0]   shift_len;
    logic [2:0]         pre_last;

    // Shift length clamped to 1..MAX_LEN
    always_comb begin
        shift_len = cmd_len;
        if (cmd_len == '0) begin
            shift_len = LEN_W'(1);
        end else if (cmd_len > MAX_LEN_W) begin
            shift_len = MAX_LEN_W;
        end
    end

    // IR needs one extra SELECT step before CAPTURE
    assign pre_last = is_ir_q ? 3'd3 : 3'd2;

    // Command sequencer: tms/tdi are set one cycle ahead of the mirror's transition
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= RST_EXIT;
            step_q    <= '0;
            bitcnt_q  <= '0;
            len_q     <= '0;
            is_ir_q   <= 1'b0;
            data_q    <= '0;
            cap_q     <= '0;
            mask_q    <= '0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                RST_EXIT: begin
                    if (step_q == 3'd0) begin
                        tms    <= 1'b0;
                        step_q <= 3'd1;
                    end else begin
                        state_q   <= READY;
                        step_q    <= 3'd0;
                        cmd_ready <= 1'b1;
                    end
                end
                READY: begin
                    tms <= 1'b0;
                    tdi <= 1'b0;
                    if (cmd_valid) begin
                        cap_q   <= '0;
                        mask_q  <= {{(MAX_LEN - 1){1'b0}}, 1'b1};
                        data_q  <= cmd_data;
                        is_ir_q <= (cmd_op == OP_SHIFT_IR);
                        case (cmd_op)
                            OP_TAP_RESET: begin
                                cmd_ready <= 1'b0;
                                state_q   <= TLR_SEQ;
                                step_q    <= 3'd1;
                                tms       <= 1'b1;
                            end
                            OP_IDLE: begin
                                if (cmd_len == '0) begin
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= '0;
                                end else begin
                                    cmd_ready <= 1'b0;
                                    state_q   <= IDLE_RUN;
                                    bitcnt_q  <= cmd_len;
                                end
                            end
                            default: begin
                                cmd_ready <= 1'b0;
                                state_q   <= PRE;
                                step_q    <= 3'd0;
                                len_q     <= shift_len;
                                tms       <= 1'b1;
                            end
                        endcase
                    end
                end
                TLR_SEQ: begin
                    if (step_q == 3'd6) begin
                        state_q   <= READY;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap_q;
                        tms       <= 1'b0;
                    end else begin
                        step_q <= step_q + 3'd1;
                        tms    <= (step_q != 3'd5);
                    end
                end
                IDLE_RUN: begin
                    if (bitcnt_q == LEN_W'(1)) begin
                        state_q   <= READY;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap_q;
                    end else begin
                        bitcnt_q <= bitcnt_q - LEN_W'(1);
                    end
                end
                PRE: begin
                    if (step_q == pre_last) begin
                        state_q  <= SHIFT;
                        bitcnt_q <= '0;
                        tms      <= (len_q == LEN_W'(1));
                        tdi      <= data_q[0];
                        data_q   <= data_q >> 1;
                    end else begin
                        step_q <= step_q + 3'd1;
                        tms    <= is_ir_q && (step_q == 3'd0);
                    end
                end
                SHIFT: begin
                    if (tdo) begin
                        cap_q <= cap_q | mask_q;
                    end
                    mask_q <= mask_q << 1;
                    if (bitcnt_q == len_q - LEN_W'(1)) begin
                        state_q <= POST;
                        step_q  <= 3'd0;
                        tms     <= 1'b1;
                        tdi     <= 1'b0;
                    end else begin
                        bitcnt_q <= bitcnt_q + LEN_W'(1);
                        tdi      <= data_q[0];
                        data_q   <= data_q >> 1;
                        tms      <= ((bitcnt_q + LEN_W'(2)) == len_q);
                    end
                end
                POST: begin
                    if (step_q == 3'd0) begin
                        step_q <= 3'd1;
                        tms    <= 1'b0;
                    end else begin
                        state_q   <= READY;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap_q;
                        tms       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RST_EXIT;
                    step_q  <= 3'd0;
                end
            endcase
        end
    end

    jtag_tap_mirror u_mirror (
        .CLK       (CLK),
        .RESET     (RESET),
        .tms       (tms),
        .tap_state (tap_state)
    );

endmodule

// File: tb/tb_jtag_host_driver.sv
// Self-checking bench for jtag_host_driver: per-cycle reference model plus directed checks.
module tb_jtag_host_driver;

    localparam int LEN_W = 6;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic [3:0]  tap_state;

    int   tdo_mode = 1;  // 0 random, 1 loopback of tdi, 2 constant one
    logic tdo_rand = 1'b0;
    assign tdo = (tdo_mode == 1) ? tdi : (tdo_mode == 2) ? 1'b1 : tdo_rand;

    jtag_host_driver dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tap_state (tap_state)
    );

    initial forever #5 CLK = ~CLK;

    initial forever begin
        @(negedge CLK);
        tdo_rand = 1'($urandom);
    end

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // TAP transition tables indexed by state, for tms=0 and tms=1
    int nx0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nx1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    // Reference model: each command expands into a list of per-cycle (tms, tdi, bit) records
    typedef struct {
        bit tms;
        bit tdi;
        int bidx;
    } rec_t;

    rec_t        q[$];
    rec_t        cur;
    bit          busy = 1'b0;
    int          rexit = 0;
    logic [31:0] cap = '0;
    logic        e_tms = 1'b1;
    logic        e_tdi = 1'b0;
    logic        e_ready = 1'b0;
    logic        e_valid = 1'b0;
    logic [31:0] e_data = '0;
    logic [3:0]  e_tap = 4'd15;

    task automatic push(input bit t, input bit d, input int b);
        rec_t r;
        r.tms = t;
        r.tdi = d;
        r.bidx = b;
        q.push_back(r);
    endtask

    task automatic build(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int n;
        q.delete();
        if (op == 2'd0) begin
            for (int i = 0; i < 5; i++) push(1'b1, 1'b0, -1);
            push(1'b0, 1'b0, -1);
        end else if (op == 2'd1) begin
            for (int i = 0; i < int'(len); i++) push(1'b0, 1'b0, -1);
        end else begin
            n = (len == 0) ? 1 : (len > 32) ? 32 : int'(len);
            push(1'b1, 1'b0, -1);
            if (op == 2'd2) push(1'b1, 1'b0, -1);
            push(1'b0, 1'b0, -1);
            push(1'b0, 1'b0, -1);
            for (int i = 0; i < n; i++) push(i == n - 1, bit'(data >> i), i);
            push(1'b1, 1'b0, -1);
            push(1'b0, 1'b0, -1);
        end
    endtask

    initial forever begin
        @(posedge CLK or posedge RESET);
        if (RESET) begin
            e_tms = 1'b1; e_tdi = 1'b0; e_ready = 1'b0; e_valid = 1'b0;
            e_data = '0; e_tap = 4'd15;
            q.delete(); busy = 1'b0; rexit = 0; cur.bidx = -1;
        end else begin
            e_tap = e_tms ? 4'(nx1[e_tap]) : 4'(nx0[e_tap]);
            if (busy && cur.bidx >= 0) cap = cap | (32'(tdo) << cur.bidx);
            e_valid = 1'b0;
            if (rexit == 0) begin
                e_tms = 1'b0;
                rexit = 1;
            end else if (rexit == 1) begin
                e_ready = 1'b1;
                rexit = 2;
            end else if (busy) begin
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    e_tms = cur.tms;
                    e_tdi = cur.tdi;
                end else begin
                    busy = 1'b0; e_valid = 1'b1; e_ready = 1'b1; e_data = cap;
                    e_tms = 1'b0; e_tdi = 1'b0; cur.bidx = -1;
                end
            end else if (e_ready && cmd_valid) begin
                build(cmd_op, cmd_len, cmd_data);
                cap = '0;
                if (q.size() == 0) begin
                    e_valid = 1'b1;
                    e_data = '0;
                end else begin
                    cur = q.pop_front();
                    e_tms = cur.tms; e_tdi = cur.tdi; e_ready = 1'b0; busy = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            chk("tms", 32'(tms), 32'(e_tms));
            chk("tdi", 32'(tdi), 32'(e_tdi));
            chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
            chk("rsp_data", rsp_data, e_data);
            chk("tap_state", 32'(tap_state), 32'(e_tap));
        end
    end

    logic [3:0] tr_tap [64];
    bit         tr_tms [64];
    bit         tr_tdi [64];

    // Called at a negedge; returns at the negedge of the first cycle after acceptance
    task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int w = 0;
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        while (!cmd_ready && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 200) begin
            total++; bad++;
            $display("FAIL send_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_data = $urandom;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                           output int ncyc, output int nbit);
        send(op, len, data);
        ncyc = 0;
        nbit = 0;
        while (!rsp_valid && ncyc < 300) begin
            if (ncyc < 64) begin
                tr_tap[ncyc] = tap_state; tr_tms[ncyc] = tms; tr_tdi[ncyc] = tdi;
            end
            if (tap_state == 4'd2 || tap_state == 4'd10) nbit++;
            cmd_valid = 1'($urandom);
            cmd_data = $urandom;
            cmd_op = 2'($urandom);
            @(negedge CLK);
            ncyc++;
        end
        cmd_valid = 1'b0;
        if (ncyc >= 300) begin
            total++; bad++;
            $display("FAIL rsp_timeout: rsp_valid stayed 0 after %0d cycles, required 1", ncyc);
        end
    endtask

    int ncyc, nbit, k, w;
    int dr_tms [13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    int dr_tdi [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int ir_tap [9] = '{7, 4, 14, 10, 10, 10, 10, 9, 13};
    int tlr_tap [5] = '{7, 4, 15, 15, 15};
    logic [31:0] d;

    initial begin
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        chk("rst_tms", 32'(tms), 32'd1);
        chk("rst_tap", 32'(tap_state), 32'd15);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        #2 RESET = 1'b0;
        @(negedge CLK);
        chk("exit_tms", 32'(tms), 32'd0);
        chk("exit_ready", 32'(cmd_ready), 32'd0);
        @(negedge CLK);
        chk("entry_tap", 32'(tap_state), 32'd12);
        chk("entry_ready", 32'(cmd_ready), 32'd1);

        // SHIFT_DR 8 bits, tdo looped back
        tdo_mode = 1;
        run_cmd(2'd3, 6'd8, 32'hA5, ncyc, nbit);
        chk("dr8_cycles", 32'(ncyc), 32'd13);
        for (int i = 0; i < 13; i++) chk("dr8_tms", 32'(tr_tms[i]), 32'(dr_tms[i]));
        k = 0;
        for (int i = 0; i < 13; i++) begin
            if (tr_tap[i] == 4'd2 && k < 8) begin
                chk("dr8_tdi", 32'(tr_tdi[i]), 32'(dr_tdi[k]));
                k++;
            end
        end
        chk("dr8_nbits", 32'(k), 32'd8);
        chk("dr8_data", rsp_data, 32'hA5);

        // SHIFT_IR 4 bits, tdo tied high
        tdo_mode = 2;
        run_cmd(2'd2, 6'd4, 32'h3, ncyc, nbit);
        chk("ir4_cycles", 32'(ncyc), 32'd10);
        for (int i = 0; i < 9; i++) chk("ir4_tap", 32'(tr_tap[i + 1]), 32'(ir_tap[i]));
        chk("ir4_end_tap", 32'(tap_state), 32'd12);
        chk("ir4_data", rsp_data, 32'hF);

        // TAP_RESET from RUN_TEST_IDLE
        tdo_mode = 0;
        run_cmd(2'd0, 6'd0, 32'h0, ncyc, nbit);
        chk("tlr_cycles", 32'(ncyc), 32'd6);
        for (int i = 0; i < 5; i++) chk("tlr_tap", 32'(tr_tap[i + 1]), 32'(tlr_tap[i]));
        chk("tlr_data", rsp_data, 32'h0);

        run_cmd(2'd1, 6'd0, 32'h0, ncyc, nbit);
        chk("idle0_cycles", 32'(ncyc), 32'd0);
        run_cmd(2'd1, 6'd5, 32'h0, ncyc, nbit);
        chk("idle5_cycles", 32'(ncyc), 32'd5);
        run_cmd(2'd3, 6'd40, $urandom, ncyc, nbit);
        chk("dr40_bits", 32'(nbit), 32'd32);
        chk("dr40_cycles", 32'(ncyc), 32'd37);
        run_cmd(2'd3, 6'd0, $urandom, ncyc, nbit);
        chk("dr0_bits", 32'(nbit), 32'd1);
        chk("dr0_cycles", 32'(ncyc), 32'd6);

        // Reset in the middle of DR bit cycles
        send(2'd3, 6'd16, $urandom);
        w = 0;
        while (tap_state != 4'd2 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        chk("mid_reached_shift", 32'(tap_state), 32'd2);
        repeat (3) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_tms", 32'(tms), 32'd1);
        chk("mid_rst_tdi", 32'(tdi), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_tap", 32'(tap_state), 32'd15);
        repeat (2) @(negedge CLK);
        #2 RESET = 1'b0;
        @(negedge CLK);
        tdo_mode = 1;
        d = $urandom;
        run_cmd(2'd3, 6'd8, d, ncyc, nbit);
        chk("post_rst_data", rsp_data, {24'd0, d[7:0]});

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 150; n++) begin
            logic [1:0] op;
            logic [5:0] len;
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            tdo_mode = $urandom_range(0, 2);
            op = 2'($urandom);
            len = (op == 2'd1) ? 6'($urandom_range(0, 12)) : 6'($urandom_range(0, 40));
            run_cmd(op, len, $urandom, ncyc, nbit);
        end

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_host_driver.md
Name: jtag_host_driver

Overview:
- Host-side JTAG driver; it is the initiator that steers a TAP controller with TMS and TDI, on the same clock as the TAP.
- Accepts high-level commands (TAP reset, idle clocks, IR shift, DR shift) over a valid/ready interface.
- Generates the cycle-exact TMS/TDI sequence, captures TDO, and returns the captured bits.
- Keeps a mirror of the target TAP state, using the shared 4-bit TAP encoding.

Parameters:
- MAX_LEN, 32, maximum shift length in bits.
- LEN_W, $clog2(MAX_LEN+1), width of cmd_len.

Ports:
- CLK  in  1  clock, shared with the target TAP.
- RESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  driver idle in RUN_TEST_IDLE and able to accept a command.
- cmd_op  in  2  0=TAP_RESET, 1=IDLE, 2=SHIFT_IR, 3=SHIFT_DR.
- cmd_len  in  LEN_W  IDLE: number of cycles; SHIFT: number of bits.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rsp_data  out  MAX_LEN  captured TDO bits, right-justified, LSB first; holds until the next rsp_valid.
- tms  out  1  TMS to the target.
- tdi  out  1  TDI to the target.
- tdo  in  1  TDO from the target, sampled at CLK edges.
- tap_state  out  4  mirrored TAP state.

Behaviour:
- Reset values: tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, tap_state=TEST_LOGIC_RESET (15).
- After RESET deasserts:
  - one cycle with tms=0 drives the mirror to RUN_TEST_IDLE (12);
  - cmd_ready=1 from the following cycle.
- Mirror tracking: tap_state advances every CLK using the standard TAP next-state function applied to the driven tms. tap_state always equals the target state.
- Accept: on the edge where cmd_valid && cmd_ready.
  - Latch op, len and data; cmd_ready drops to 0.
  - The sequence starts on the next cycle.
- Length rules (shift ops): len=0 is treated as 1; len>MAX_LEN saturates to MAX_LEN.
- TMS sequences; all start and end in RUN_TEST_IDLE:
  - TAP_RESET: tms=1,1,1,1,1 then 0 (6 cycles); rsp_data=0.
  - IDLE: tms=0 for len cycles; len=0 completes immediately; rsp_data=0.
  - SHIFT_DR: tms 1,0,0 to reach SHIFT_DR; then len bit cycles with tms=0, except the last bit with tms=1 (to EXIT1_DR); then 1,0 (UPDATE_DR, RUN_TEST_IDLE). Total len+5 cycles.
  - SHIFT_IR: tms 1,1,0,0 to reach SHIFT_IR; then len bit cycles as for DR; then 1,0. Total len+6 cycles.
- TDI and TDO during shifts:
  - In bit cycle i (mirror in SHIFT_xR): tdi=data[i], and tdo is sampled into rsp_data[i] at the closing edge.
  - rsp_data bits at and above len are 0.
  - tdi=0 in all non-bit cycles.
- Completion:
  - On the cycle the mirror re-enters RUN_TEST_IDLE: rsp_valid=1 for exactly one cycle and cmd_ready=1 in the same cycle.
  - A new command may be accepted in that cycle.
- During a command: cmd_valid is ignored and cmd_data may change without effect.
- Reset mid-command: abort immediately to the reset values, then re-run the post-reset RUN_TEST_IDLE entry. No rsp_valid is issued for the aborted command.
- FSM states: RST_EXIT, READY, PRE (path to SHIFT), SHIFT, POST (EXIT1, UPDATE, RUN_TEST_IDLE), IDLE_RUN, TLR_SEQ.
  - Counters: a step counter of 3 bits and a bit counter of LEN_W bits.

Decomposition:
- Package jtag_pkg:
  - the 16 TAP state constants (TEST_LOGIC_RESET=15, RUN_TEST_IDLE=12, SELECT_DR_SCAN=7, CAPTURE_DR=6, SHIFT_DR=2, EXIT1_DR=1, PAUSE_DR=3, EXIT2_DR=0, UPDATE_DR=5, SELECT_IR_SCAN=4, CAPTURE_IR=14, SHIFT_IR=10, EXIT1_IR=9, PAUSE_IR=11, EXIT2_IR=8, UPDATE_IR=13);
  - the cmd_op encodings;
  - a tap_next(state, tms) function.
- Sub-module jtag_tap_mirror: a registered tap_state driven by tap_next; it shares CLK/RESET and is reused by verification as a reference.

Test Plan:
- RESET pulse, then no commands -> tms=1 while in reset, one cycle tms=0, tap_state=12, cmd_ready=1 on the next cycle.
- SHIFT_DR len=8, data=0xA5, tdo looped from tdi -> tms sequence 1,0,0,0000000 1,1,0 (13 cycles); tdi pattern 1,0,1,0,0,1,0,1 in SHIFT_DR; rsp_data=0xA5; rsp_valid pulses once.
- SHIFT_IR len=4, data=0x3, tdo tied 1 -> 10 cycles; tap_state visits 7,4,14,10,10,10,10,9,13,12; rsp_data=0xF.
- TAP_RESET issued from RUN_TEST_IDLE -> tap_state 7,4,15,15,15,12; rsp_valid after 6 cycles.
- Edge cases:
  - IDLE len=0 -> rsp_valid the cycle after accept;
  - SHIFT_DR len=40 with MAX_LEN=32 -> exactly 32 bit cycles;
  - SHIFT_DR len=0 -> 1 bit cycle.
- RESET asserted in the middle of SHIFT_DR bits -> outputs return to reset values immediately; no rsp_valid; normal entry sequence after release; the next command completes correctly.
